// File: rtl/init_ram_arb_pkg.sv
// Shared definitions for the init_ram controller/arbiter: state encoding,
// requester count and default RAM geometry.
package init_ram_pkg;

    localparam int NUM_REQ       = 2;
    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_ADDRWIDTH = 10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/init_ram_arb_if.sv
// Requester-side and RAM-side signals of init_ram_arb, bundled as one bus.
// slave = the arbiter's view, master = the requesters and RAM around it.
interface init_ram_arb_if
    import init_ram_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
);
    logic                 Busy;

    logic                 Req0;
    logic                 Gnt0;
    logic [ADDRWIDTH-1:0] Addr0;
    logic [DATAWIDTH-1:0] WData0;
    logic                 We0;
    logic                 RspValid0;

    logic                 Req1;
    logic                 Gnt1;
    logic [ADDRWIDTH-1:0] Addr1;
    logic [DATAWIDTH-1:0] WData1;
    logic                 We1;
    logic                 RspValid1;

    logic [DATAWIDTH-1:0] RData;

    logic [ADDRWIDTH-1:0] RamAddr;
    logic [DATAWIDTH-1:0] RamDataIn;
    logic                 RamWriteEnable;
    logic [DATAWIDTH-1:0] RamDataOut;

    modport slave (
        output Busy,
        input  Req0, Addr0, WData0, We0,
        output Gnt0, RspValid0,
        input  Req1, Addr1, WData1, We1,
        output Gnt1, RspValid1,
        output RData,
        output RamAddr, RamDataIn, RamWriteEnable,
        input  RamDataOut
    );

    modport master (
        input  Busy,
        output Req0, Addr0, WData0, We0,
        input  Gnt0, RspValid0,
        output Req1, Addr1, WData1, We1,
        input  Gnt1, RspValid1,
        input  RData,
        input  RamAddr, RamDataIn, RamWriteEnable,
        output RamDataOut
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request wins immediately; on a tie the
// port that did not win most recently is granted. The preference only moves
// when a grant is actually issued, so idle cycles do not disturb fairness.
module rr_arb2
    import init_ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    // Index of the port that wins a tie; port 0 after reset.
    logic pref_reg;
    logic pref_next;

    // One-hot grant, suppressed entirely when disabled.
    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) begin
                gnt = pref_reg ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After a grant the other port becomes the preferred one.
    always_comb begin
        pref_next = pref_reg;
        if (gnt[0]) begin
            pref_next = 1'b1;
        end else if (gnt[1]) begin
            pref_next = 1'b0;
        end
    end

    // Preference register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_reg <= 1'b0;
        end else begin
            pref_reg <= pref_next;
        end
    end

endmodule

// File: rtl/init_ram_arb.sv
// Front end for a single-port, 1-cycle-read init_ram: optionally clears the
// whole array after reset, then shares the port between two requesters with
// round-robin grants and returns a one-cycle read-valid pulse per read.
module init_ram_arb
    import init_ram_pkg::*;
#(
    parameter int                   DATAWIDTH      = DEF_DATAWIDTH,
    parameter int                   ADDRWIDTH      = DEF_ADDRWIDTH,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE    = '0
)(
    input  logic           Clk,
    input  logic           Rst,
    init_ram_arb_if.slave  bus
);

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t               state_reg;
    state_t               state_next;
    logic [ADDRWIDTH-1:0] cnt_reg;
    logic                 cnt_last;
    logic                 busy_reg;
    logic [NUM_REQ-1:0]   rsp_reg;
    logic [ADDRWIDTH-1:0] addr_hold_reg;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   we_vec;
    logic                 arb_en;

    logic [ADDRWIDTH-1:0] ram_addr;
    logic [DATAWIDTH-1:0] ram_wdata;
    logic                 ram_we;

    // Explicit all-ones terminal compare for the clear sweep.
    assign cnt_last = (cnt_reg == {ADDRWIDTH{1'b1}});
    assign req      = {bus.Req1, bus.Req0};
    assign we_vec   = {bus.We1, bus.We0};
    // No grants while clearing or while reset is asserted.
    assign arb_en   = (state_reg == ST_RUN) && !Rst;

    rr_arb2 u_arb (
        .clk (Clk),
        .rst (Rst),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leave CLEAR once the last address has been written.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (cnt_last) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = RESET_STATE;
        endcase
    end

    // RAM port drive: clear sweep, else the granted port, else idle holding the address.
    always_comb begin
        ram_addr  = addr_hold_reg;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (state_reg == ST_CLEAR) begin
            ram_addr  = cnt_reg;
            ram_wdata = CLEAR_VALUE;
            ram_we    = 1'b1;
        end else if (gnt[0]) begin
            ram_addr  = bus.Addr0;
            ram_wdata = bus.WData0;
            ram_we    = bus.We0;
        end else if (gnt[1]) begin
            ram_addr  = bus.Addr1;
            ram_wdata = bus.WData1;
            ram_we    = bus.We1;
        end
    end

    // Clear counter, registered Busy and the idle address hold.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_reg       <= '0;
            busy_reg      <= CLEAR_ON_RESET;
            addr_hold_reg <= '0;
        end else begin
            if (state_reg == ST_CLEAR) begin
                cnt_reg <= cnt_last ? '0 : cnt_reg + ADDRWIDTH'(1);
            end
            busy_reg      <= (state_next == ST_CLEAR);
            addr_hold_reg <= ram_addr;
        end
    end

    // Read-valid pulse one cycle after a granted read; writes give none.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rsp_reg <= '0;
        end else begin
            rsp_reg <= gnt & ~we_vec;
        end
    end

    assign bus.Busy           = busy_reg;
    assign bus.Gnt0           = gnt[0];
    assign bus.Gnt1           = gnt[1];
    assign bus.RspValid0      = rsp_reg[0];
    assign bus.RspValid1      = rsp_reg[1];
    assign bus.RData          = bus.RamDataOut;
    assign bus.RamAddr        = ram_addr;
    assign bus.RamDataIn      = ram_wdata;
    assign bus.RamWriteEnable = ram_we;

endmodule

// File: tb/tb_init_ram_arb.sv
// Self-checking bench for init_ram_arb with a small behavioural RAM and a
// transaction-level reference model (memory array + "last granted" port).
module tb_init_ram_arb;
    import init_ram_pkg::*;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'hA5A5A5A5;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    init_ram_arb_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    init_ram_arb #(
        .DATAWIDTH      (DW),
        .ADDRWIDTH      (AW),
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Single-port RAM with 1-cycle read and write-through output.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge Clk) begin
        if (bus.RamWriteEnable) ram_mem[bus.RamAddr] <= bus.RamDataIn;
        bus.RamDataOut <= bus.RamWriteEnable ? bus.RamDataIn : ram_mem[bus.RamAddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last;
    logic          m_rv0, m_rv1;
    logic [DW-1:0] m_rdata;

    // Observed / expected values of the latest cycle.
    logic          o_g0, o_g1, o_rv0, o_rv1;
    logic [DW-1:0] o_rdata;
    logic          e_g0, e_g1, e_rv0, e_rv1;
    logic [DW-1:0] e_rdata;

    task automatic model_reset();
        m_last = 1;
        m_rv0  = 1'b0;
        m_rv1  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = CV;
    endtask

    task automatic set_idle();
        bus.Req0 = 1'b0; bus.Addr0 = '0; bus.WData0 = '0; bus.We0 = 1'b0;
        bus.Req1 = 1'b0; bus.Addr1 = '0; bus.WData1 = '0; bus.We1 = 1'b0;
    endtask

    // Drives one RUN cycle (entered at posedge+1), records observed outputs at
    // mid-cycle and the model's expectations, then advances to next posedge+1.
    task automatic cycle(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic w0,
                         input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic w1);
        int            win;
        logic          nrv0, nrv1;
        logic [DW-1:0] nrdata;
        bus.Req0 = r0; bus.Addr0 = a0; bus.WData0 = d0; bus.We0 = w0;
        bus.Req1 = r1; bus.Addr1 = a1; bus.WData1 = d1; bus.We1 = w1;
        #4;
        o_g0 = bus.Gnt0; o_g1 = bus.Gnt1; o_rv0 = bus.RspValid0; o_rv1 = bus.RspValid1;
        o_rdata = bus.RData;
        e_rv0 = m_rv0; e_rv1 = m_rv1; e_rdata = m_rdata;
        win = -1;
        if (r0 && r1) win = 1 - m_last;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        e_g0 = (win == 0);
        e_g1 = (win == 1);
        nrv0 = 1'b0; nrv1 = 1'b0; nrdata = m_rdata;
        if (win == 0) begin
            m_last = 0;
            if (w0) m_mem[a0] = d0;
            else begin nrv0 = 1'b1; nrdata = m_mem[a0]; end
        end else if (win == 1) begin
            m_last = 1;
            if (w1) m_mem[a1] = d1;
            else begin nrv1 = 1'b1; nrdata = m_mem[a1]; end
        end
        $display("[TB] t=%0t req=%b%b we=%b%b a0=%0d a1=%0d gnt=%b%b rsp=%b%b rdata=%h",
                 $time, r1, r0, w1, w0, a0, a1, o_g1, o_g0, o_rv1, o_rv0, o_rdata);
        @(posedge Clk); #1;
        m_rv0 = nrv0; m_rv1 = nrv1; m_rdata = nrdata;
    endtask

    // Counts Busy cycles from posedge+1 of the first cycle after reset release.
    task automatic wait_clear(output int cycles, output logic [AW-1:0] first_addr);
        cycles     = 0;
        first_addr = bus.RamAddr;
        for (int k = 0; k < 60; k++) begin
            if (!bus.Busy) break;
            cycles++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        set_idle();
        Rst = 1'b1;
        bus.Req0 = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_tests++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", bus.Busy); end
        n_tests++; if (bus.Gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0", bus.Gnt0); end
        n_tests++; if (bus.Gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got=%b exp=0", bus.Gnt1); end
        n_tests++; if ({bus.RspValid1, bus.RspValid0} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp got=%b%b exp=00", bus.RspValid1, bus.RspValid0);
        end
        Rst = 1'b0;
        model_reset();
    endtask

    // Req0 (read of address 0) is held through the whole clear.
    task automatic test_clear();
        int busy_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            if (!bus.Busy) break;
            busy_cycles++;
            n_tests++; if (bus.Gnt0 !== 1'b0) begin n_fail++; $display("FAIL clear_gnt0 cyc=%0d got=%b exp=0", k, bus.Gnt0); end
            @(posedge Clk); #1;
        end
        n_tests++; if (busy_cycles !== 16) begin n_fail++; $display("FAIL clear_busy_cycles got=%0d exp=16", busy_cycles); end
        cycle(1'b1, 4'd0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1 || o_g1 !== 1'b0) begin n_fail++; $display("FAIL clear_first_gnt got=%b%b exp=01", o_g1, o_g0); end
        cycle(1'b1, 4'd15, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_rv0 !== 1'b1 || o_rdata !== CV) begin n_fail++; $display("FAIL clear_rd0 rv=%b data=%h exp rv=1 data=%h", o_rv0, o_rdata, CV); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_rv0 !== 1'b1 || o_rdata !== CV) begin n_fail++; $display("FAIL clear_rd15 rv=%b data=%h exp rv=1 data=%h", o_rv0, o_rdata, CV); end
    endtask

    task automatic test_write_read();
        cycle(1'b1, 4'd3, 32'h12345678, 1'b1, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1) begin n_fail++; $display("FAIL wr_gnt0 got=%b exp=1", o_g0); end
        cycle(1'b1, 4'd3, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1 || o_rv0 !== 1'b0) begin n_fail++; $display("FAIL rd_gnt0 gnt=%b rv=%b exp gnt=1 rv=0", o_g0, o_rv0); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_rv0 !== 1'b1 || o_rv1 !== 1'b0 || o_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_rd_data rv=%b%b data=%h exp rv=01 data=12345678", o_rv1, o_rv0, o_rdata);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] pa0, pa1;
        pa0 = AW'($urandom_range(0, DEPTH-1));
        pa1 = AW'($urandom_range(0, DEPTH-1));
        for (int k = 0; k < 5; k++) begin
            cycle(k < 4, pa0, '0, 1'b0, k < 4, pa1, '0, 1'b0);
            n_tests++; if ({o_g1, o_g0} !== {e_g1, e_g0}) begin n_fail++; $display("FAIL cont_gnt k=%0d got=%b%b exp=%b%b", k, o_g1, o_g0, e_g1, e_g0); end
            n_tests++; if ({o_rv1, o_rv0} !== {e_rv1, e_rv0}) begin n_fail++; $display("FAIL cont_rsp k=%0d got=%b%b exp=%b%b", k, o_rv1, o_rv0, e_rv1, e_rv0); end
            if (e_rv0 || e_rv1) begin
                n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL cont_rdata k=%0d got=%h exp=%h", k, o_rdata, e_rdata); end
            end
            if (e_g0) pa0 = AW'($urandom_range(0, DEPTH-1));
            if (e_g1) pa1 = AW'($urandom_range(0, DEPTH-1));
        end
    endtask

    task automatic test_fairness();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, '0, 1'b0);
        n_tests++; if (o_g1 !== 1'b1) begin n_fail++; $display("FAIL fair_gnt1 got=%b exp=1", o_g1); end
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 4'd3, '0, 1'b0, 1'b1, 4'd5, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1 || o_g1 !== 1'b0) begin n_fail++; $display("FAIL fair_both got=%b%b exp=01", o_g1, o_g0); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, '0, 1'b0);
        n_tests++; if (o_g1 !== 1'b1 || o_rv0 !== 1'b1 || o_rdata !== e_rdata) begin
            n_fail++; $display("FAIL fair_second gnt1=%b rv0=%b data=%h exp 1 1 %h", o_g1, o_rv0, o_rdata, e_rdata);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_random();
        logic          act0, act1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        act0 = 1'b0; act1 = 1'b0;
        w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int k = 0; k < 150; k++) begin
            if (!act0) begin
                act0 = ($urandom_range(0, 2) != 0);
                a0 = AW'($urandom_range(0, DEPTH-1)); d0 = $urandom; w0 = 1'($urandom_range(0, 1));
            end
            if (!act1) begin
                act1 = ($urandom_range(0, 2) != 0);
                a1 = AW'($urandom_range(0, DEPTH-1)); d1 = $urandom; w1 = 1'($urandom_range(0, 1));
            end
            cycle(act0, a0, d0, w0, act1, a1, d1, w1);
            n_tests++; if ({o_g1, o_g0} !== {e_g1, e_g0}) begin n_fail++; $display("FAIL rand_gnt k=%0d got=%b%b exp=%b%b", k, o_g1, o_g0, e_g1, e_g0); end
            n_tests++; if ({o_rv1, o_rv0} !== {e_rv1, e_rv0}) begin n_fail++; $display("FAIL rand_rsp k=%0d got=%b%b exp=%b%b", k, o_rv1, o_rv0, e_rv1, e_rv0); end
            if (e_rv0 || e_rv1) begin
                n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", k, o_rdata, e_rdata); end
            end
            if (e_g0) act0 = 1'b0;
            if (e_g1) act1 = 1'b0;
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if ({o_rv1, o_rv0} !== {e_rv1, e_rv0}) begin n_fail++; $display("FAIL rand_drain got=%b%b exp=%b%b", o_rv1, o_rv0, e_rv1, e_rv0); end
    endtask

    task automatic test_reset_mid_clear();
        int            cyc;
        logic [AW-1:0] fa;
        set_idle();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        repeat (7) begin @(posedge Clk); #1; end
        n_tests++; if (bus.RamAddr !== AW'(7)) begin n_fail++; $display("FAIL midclr_addr7 got=%0d exp=7", bus.RamAddr); end
        Rst = 1'b1;
        #1;
        n_tests++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy got=%b exp=1", bus.Busy); end
        n_tests++; if (bus.RamAddr !== '0) begin n_fail++; $display("FAIL midclr_addr_restart got=%0d exp=0", bus.RamAddr); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        wait_clear(cyc, fa);
        n_tests++; if (cyc !== 16) begin n_fail++; $display("FAIL midclr_cycles got=%0d exp=16", cyc); end
        n_tests++; if (fa !== '0) begin n_fail++; $display("FAIL midclr_first_addr got=%0d exp=0", fa); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd9, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_rv1 !== 1'b1 || o_rdata !== CV) begin n_fail++; $display("FAIL midclr_read rv1=%b data=%h exp 1 %h", o_rv1, o_rdata, CV); end
    endtask

    task automatic test_reset_after_read();
        int            cyc;
        logic [AW-1:0] fa;
        cycle(1'b1, 4'd2, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1) begin n_fail++; $display("FAIL rar_gnt0 got=%b exp=1", o_g0); end
        Rst = 1'b1;
        set_idle();
        #1;
        n_tests++; if ({bus.RspValid1, bus.RspValid0} !== 2'b00) begin
            n_fail++; $display("FAIL rar_rsp_killed got=%b%b exp=00", bus.RspValid1, bus.RspValid0);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        wait_clear(cyc, fa);
        n_tests++; if (cyc !== 16) begin n_fail++; $display("FAIL rar_clear_cycles got=%0d exp=16", cyc); end
        cycle(1'b1, 4'd1, '0, 1'b0, 1'b1, 4'd2, '0, 1'b0);
        n_tests++; if (o_g0 !== 1'b1 || o_g1 !== 1'b0) begin n_fail++; $display("FAIL rar_pointer got=%b%b exp=01", o_g1, o_g0); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, '0, 1'b0);
        n_tests++; if (o_g1 !== 1'b1 || o_rv0 !== 1'b1) begin n_fail++; $display("FAIL rar_second gnt1=%b rv0=%b exp 1 1", o_g1, o_rv0); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (o_rv1 !== 1'b1 || o_rv0 !== 1'b0) begin n_fail++; $display("FAIL rar_rsp1 got=%b%b exp=10", o_rv1, o_rv0); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_contention();
        test_fairness();
        test_random();
        test_reset_mid_clear();
        test_reset_after_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
